tcam_result_buffer: RTL and testbench

Downstream consumer of the TCAM lookup port. Captures each `valid`/`data_out` result from the `tcam` block with a four-phase `ack` handshake, queues results in a small first-word-fall-through FIFO, and presents them to the next stage with a ready/valid interface. Keeps a saturating hit counter for debug. When the FIFO is full it applies backpressure by withholding `ack`, so the TCAM holds its result.

---
 rtl/tcam_result_buffer_if.sv | 26 ++
 rtl/tcam_result_buffer.sv | 94 +++++++++
 tb/tb_tcam_result_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_result_buffer_if.sv
// Bundles the TCAM-facing handshake and the downstream ready/valid stream of
// tcam_result_buffer into one interface.
interface tcam_result_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                  tcam_valid;
    logic [DATA_WIDTH-1:0] tcam_data;
    logic                  tcam_ack;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [DEPTH_LOG2:0]   level;
    logic [CNT_WIDTH-1:0]  hit_cnt;

    modport master (
        output tcam_valid, tcam_data, out_ready,
        input  tcam_ack, out_valid, out_data, level, hit_cnt
    );

    modport slave (
        input  tcam_valid, tcam_data, out_ready,
        output tcam_ack, out_valid, out_data, level, hit_cnt
    );
endinterface

// File: rtl/tcam_result_buffer.sv
// Captures TCAM results with a four-phase ack handshake into a small FWFT FIFO
// and streams them downstream; keeps a saturating hit counter.
module tcam_result_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    tcam_result_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  capture;
    logic                  pop;

    // Fullness uses the registered level, so a same-cycle pop cannot open a slot.
    assign capture = (state_q == IDLE) && bus.tcam_valid && (level_q != LVL_FULL) && !clr;
    assign pop     = (level_q != '0) && bus.out_ready && !clr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = ACK;
            ACK:     if (!bus.tcam_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        mem_d     = mem_q;
        if (capture) begin
            mem_d[wr_ptr_q] = bus.tcam_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (capture && !pop)      level_d = level_q + LVL_ONE;
        else if (!capture && pop) level_d = level_q - LVL_ONE;
        // Flush leaves the handshake FSM alone; only queue and counter are cleared.
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            hit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            hit_cnt_q <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.tcam_ack  = (state_q == ACK);
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_tcam_result_buffer.sv
// Self-checking bench for tcam_result_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_tcam_result_buffer;
    localparam int DW = 8;
    localparam int DL = 2;
    localparam int CW = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] seen_q[$];
    logic [DW-1:0] want_q[$];
    bit            exp_ack;
    int            exp_hit;

    tcam_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) bus ();

    tcam_result_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        seen_q.delete();
        want_q.delete();
        exp_ack = 1'b0;
        exp_hit = 0;
    endtask

    // One clock edge: the model applies the rules to the inputs present at the edge.
    task automatic tick();
        bit            tv, cap, pp, cl;
        logic [DW-1:0] td;
        tv  = bus.tcam_valid;
        td  = bus.tcam_data;
        cl  = clr;
        cap = !exp_ack && tv && (exp_q.size() < (1 << DL)) && !cl;
        pp  = (exp_q.size() != 0) && bus.out_ready && !cl;
        if (pp) begin
            seen_q.push_back(bus.out_data);
            want_q.push_back(exp_q[0]);
        end
        @(posedge clk);
        if (cl) begin
            exp_q.delete();
            exp_hit = 0;
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (cap) begin
                exp_q.push_back(td);
                if (exp_hit < CNT_SAT) exp_hit++;
            end
        end
        exp_ack = exp_ack ? tv : cap;
        #1;
    endtask

    task automatic deliver(input logic [DW-1:0] d, input int hold);
        bus.tcam_data  = d;
        bus.tcam_valid = 1'b1;
        for (int i = 0; i < 20 && !exp_ack; i++) tick();
        repeat (hold) tick();
        bus.tcam_valid = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        seen_q.delete();
        want_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        bus.tcam_valid = 1'b0;
        bus.tcam_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b want 0", bus.tcam_ack); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d want 0", bus.level); end
        vectors++; if (bus.hit_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_hit_cnt: got %0d want 0", bus.hit_cnt); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bus.tcam_data = 8'hFF;
        bus.tcam_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (bus.tcam_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ack_hold%0d: got %b want 1", c, bus.tcam_ack); end
            vectors++; if (bus.level !== 3'd1) begin miscompares++; $display("[TB] FAIL single_level%0d: got %0d want 1", c, bus.level); end
        end
        bus.tcam_valid = 1'b0;
        tick();
        vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ack_release: got %b want 0", bus.tcam_ack); end
        vectors++; if (bus.out_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL single_data: got %h want ff", bus.out_data); end
        vectors++; if (bus.hit_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL single_hit: got %0d want 1", bus.hit_cnt); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_out_valid: got %b want 1", bus.out_valid); end
    endtask

    task automatic test_fill_backpressure();
        logic [DW-1:0] ref_seq [5];
        ref_seq = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
        do_clr();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) deliver(ref_seq[i], int'($urandom_range(0, 1)));
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_level: got %0d want 4", bus.level); end
        bus.tcam_data = ref_seq[4];
        bus.tcam_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ack_withheld%0d: got %b want 0", c, bus.tcam_ack); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (bus.level !== 3'd3) begin miscompares++; $display("[TB] FAIL pop_level: got %0d want 3", bus.level); end
        vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL pop_no_same_edge_capture: got %b want 0", bus.tcam_ack); end
        vectors++; if (seen_q.size() != 1 || seen_q[0] !== 8'hFF) begin miscompares++; $display("[TB] FAIL pop_head: got %0d pops want one ff", seen_q.size()); end
        tick();
        vectors++; if (bus.tcam_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL late_capture_ack: got %b want 1", bus.tcam_ack); end
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("[TB] FAIL late_capture_level: got %0d want 4", bus.level); end
        vectors++; if (bus.hit_cnt !== 4'd5) begin miscompares++; $display("[TB] FAIL late_capture_hit: got %0d want 5", bus.hit_cnt); end
        bus.tcam_valid = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        vectors++; if (seen_q.size() != 5) begin miscompares++; $display("[TB] FAIL drain_count: got %0d want 5", seen_q.size()); end
        for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
            vectors++; if (seen_q[i] !== ref_seq[i]) begin miscompares++; $display("[TB] FAIL drain_order%0d: got %h want %h", i, seen_q[i], ref_seq[i]); end
        end
    endtask

    task automatic test_order_wrap();
        do_clr();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) deliver(8'(i), int'($urandom_range(0, 2)));
        repeat (2) tick();
        bus.out_ready = 1'b0;
        vectors++; if (bus.hit_cnt !== 4'd10) begin miscompares++; $display("[TB] FAIL order_hit: got %0d want 10", bus.hit_cnt); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("[TB] FAIL order_level: got %0d want 0", bus.level); end
        vectors++; if (seen_q.size() != 10) begin miscompares++; $display("[TB] FAIL order_count: got %0d want 10", seen_q.size()); end
        for (int i = 0; i < 10 && i < seen_q.size(); i++) begin
            vectors++; if (seen_q[i] !== 8'(i + 1)) begin miscompares++; $display("[TB] FAIL order_item%0d: got %h want %h", i, seen_q[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] a, b, c;
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        do_clr();
        bus.out_ready = 1'b0;
        deliver(a, 0);
        deliver(b, 0);
        vectors++; if (bus.level !== 3'd2) begin miscompares++; $display("[TB] FAIL pushpop_pre_level: got %0d want 2", bus.level); end
        bus.tcam_data = c;
        bus.tcam_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (bus.level !== 3'd2) begin miscompares++; $display("[TB] FAIL pushpop_level: got %0d want 2", bus.level); end
        vectors++; if (bus.tcam_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL pushpop_ack: got %b want 1", bus.tcam_ack); end
        vectors++; if (bus.out_data !== b) begin miscompares++; $display("[TB] FAIL pushpop_head: got %h want %h", bus.out_data, b); end
        vectors++; if (seen_q.size() != 1 || seen_q[0] !== a) begin miscompares++; $display("[TB] FAIL pushpop_popped: got %0d pops want one %h", seen_q.size(), a); end
        bus.tcam_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [DW-1:0] d;
        d = 8'($urandom);
        do_clr();
        bus.out_ready = 1'b0;
        repeat (3) deliver(8'($urandom), 0);
        vectors++; if (bus.level !== 3'd3) begin miscompares++; $display("[TB] FAIL flush_pre_level: got %0d want 3", bus.level); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("[TB] FAIL flush_level: got %0d want 0", bus.level); end
        vectors++; if (bus.hit_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_hit: got %0d want 0", bus.hit_cnt); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        clr = 1'b1;
        bus.tcam_data = d;
        bus.tcam_valid = 1'b1;
        tick();
        clr = 1'b0;
        vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_wins_ack: got %b want 0", bus.tcam_ack); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("[TB] FAIL clr_wins_level: got %0d want 0", bus.level); end
        tick();
        vectors++; if (bus.tcam_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL after_clr_ack: got %b want 1", bus.tcam_ack); end
        vectors++; if (bus.level !== 3'd1) begin miscompares++; $display("[TB] FAIL after_clr_level: got %0d want 1", bus.level); end
        vectors++; if (bus.out_data !== d) begin miscompares++; $display("[TB] FAIL after_clr_data: got %h want %h", bus.out_data, d); end
        vectors++; if (bus.hit_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL after_clr_hit: got %0d want 1", bus.hit_cnt); end
        bus.tcam_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        do_clr();
        bus.out_ready = 1'b1;
        repeat (CNT_SAT + 3) deliver(8'($urandom), 0);
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (bus.hit_cnt !== 4'(CNT_SAT)) begin miscompares++; $display("[TB] FAIL hit_saturate: got %0d want %0d", bus.hit_cnt, CNT_SAT); end
    endtask

    task automatic test_random();
        do_clr();
        for (int n = 0; n < 600; n++) begin
            bus.tcam_valid = ($urandom_range(0, 2) != 0);
            bus.tcam_data  = 8'($urandom);
            bus.out_ready  = $urandom_range(0, 1) == 1;
            clr            = ($urandom_range(0, 39) == 0);
            tick();
            clr = 1'b0;
            vectors++; if (bus.tcam_ack !== exp_ack) begin miscompares++; $display("[TB] FAIL rand_ack@%0d: got %b want %b", n, bus.tcam_ack, exp_ack); end
            vectors++; if (bus.level !== 3'(exp_q.size())) begin miscompares++; $display("[TB] FAIL rand_level@%0d: got %0d want %0d", n, bus.level, exp_q.size()); end
            vectors++; if (bus.out_valid !== (exp_q.size() != 0)) begin miscompares++; $display("[TB] FAIL rand_out_valid@%0d: got %b want %b", n, bus.out_valid, exp_q.size() != 0); end
            vectors++; if (bus.hit_cnt !== 4'(exp_hit)) begin miscompares++; $display("[TB] FAIL rand_hit@%0d: got %0d want %0d", n, bus.hit_cnt, exp_hit); end
            if (exp_q.size() != 0) begin
                vectors++; if (bus.out_data !== exp_q[0]) begin miscompares++; $display("[TB] FAIL rand_data@%0d: got %h want %h", n, bus.out_data, exp_q[0]); end
            end
        end
        bus.tcam_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        vectors++; if (seen_q.size() != want_q.size()) begin miscompares++; $display("[TB] FAIL rand_pop_count: got %0d want %0d", seen_q.size(), want_q.size()); end
        for (int i = 0; i < seen_q.size() && i < want_q.size(); i++) begin
            vectors++; if (seen_q[i] !== want_q[i]) begin miscompares++; $display("[TB] FAIL rand_pop%0d: got %h want %h", i, seen_q[i], want_q[i]); end
        end
    endtask

    task automatic test_reset_midhandshake();
        do_clr();
        bus.out_ready = 1'b0;
        bus.tcam_data = 8'($urandom);
        bus.tcam_valid = 1'b1;
        tick();
        vectors++; if (bus.tcam_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pre_ack: got %b want 1", bus.tcam_ack); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.tcam_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ack: got %b want 0", bus.tcam_ack); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("[TB] FAIL midrst_level: got %0d want 0", bus.level); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.hit_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL midrst_hit: got %0d want 0", bus.hit_cnt); end
        bus.tcam_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_order_wrap();
        test_push_pop();
        test_flush();
        test_saturate();
        test_random();
        test_reset_midhandshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
